// File: rtl/pe_dmem_arbiter_pkg.sv
// Shared cluster definitions: bus width defaults, arbiter FSM encoding and a helper
// for indexing slices of the flattened per-PE buses.
package cluster_pkg;

   localparam int unsigned NUM_PE_DEF = 4;
   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StWaitRd = 2'd2
   } arb_state_e;

   // Low bit of slice idx in a bus built from width-bit slices.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/pe_dmem_arbiter_if.sv
// Data-memory port bundle: master issues req/we/addr/wdata, slave returns ready and
// read data.
interface pe_dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ready, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata);

endinterface

// File: rtl/pe_dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Also meant for the instruction-memory arbiter.
module rr_picker #(
   parameter int unsigned NUM_PE = 4,
   parameter int unsigned IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic [NUM_PE-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_PE-1:0] gnt,
   output logic [IDX_W-1:0]  idx
);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         cand = IDX_W'((32'(ptr) + k) % NUM_PE);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/pe_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_PE PEs, one transaction
// in flight. Define DMEM_ARB_TIMEOUT_EN to abort transactions after TIMEOUT_CYC cycles.
module pe_dmem_arbiter
   import cluster_pkg::*;
#(
   parameter int unsigned NUM_PE      = NUM_PE_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_PE-1:0]        pe_req,
   input  logic [NUM_PE-1:0]        pe_we,
   input  logic [NUM_PE*ADDR_W-1:0] pe_addr,
   input  logic [NUM_PE*DATA_W-1:0] pe_wdata,
   output logic [NUM_PE-1:0]        pe_gnt,
   output logic [NUM_PE-1:0]        pe_resp_valid,
   output logic [NUM_PE*DATA_W-1:0] pe_rdata,
   output logic [NUM_PE-1:0]        pe_resp_err,
   pe_dmem_arbiter_if.master        mem
);

   localparam int unsigned IdxW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   arb_state_e        state_q;
   logic [IdxW-1:0]   rr_ptr_q;
   logic [IdxW-1:0]   owner_q;
   logic [NUM_PE-1:0] win_gnt;
   logic [IdxW-1:0]   win_idx;
   logic [IdxW-1:0]   next_ptr;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   rr_picker #(
      .NUM_PE (NUM_PE),
      .IDX_W  (IdxW)
   ) u_picker (
      .req (pe_req),
      .ptr (rr_ptr_q),
      .gnt (win_gnt),
      .idx (win_idx)
   );

   assign next_ptr = (win_idx == IdxW'(NUM_PE - 1)) ? '0 : win_idx + 1'b1;

   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int unsigned i = 0; i < NUM_PE; i++) begin
         if (win_idx == IdxW'(i)) begin
            win_we    = pe_we[i];
            win_addr  = pe_addr[slice_lo(i, ADDR_W) +: ADDR_W];
            win_wdata = pe_wdata[slice_lo(i, DATA_W) +: DATA_W];
         end
      end
   end

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   logic [CntW-1:0] cnt_q;
   logic            timeout;

   assign timeout = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
   assign pe_resp_err = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         rr_ptr_q      <= '0;
         owner_q       <= '0;
         pe_gnt        <= '0;
         pe_resp_valid <= '0;
         pe_rdata      <= '0;
         mem.req       <= 1'b0;
         mem.we        <= 1'b0;
         mem.addr      <= '0;
         mem.wdata     <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
         cnt_q         <= '0;
         pe_resp_err   <= '0;
`endif
      end else begin
         pe_gnt        <= '0;
         pe_resp_valid <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
         pe_resp_err   <= '0;
         // Abort wins over a same-cycle acceptance or read return.
         if (timeout) begin
            mem.req                <= 1'b0;
            pe_resp_valid[owner_q] <= 1'b1;
            pe_resp_err[owner_q]   <= 1'b1;
            for (int unsigned i = 0; i < NUM_PE; i++) begin
               if (owner_q == IdxW'(i)) pe_rdata[slice_lo(i, DATA_W) +: DATA_W] <= '0;
            end
            state_q <= StIdle;
         end else
`endif
         begin
`ifdef DMEM_ARB_TIMEOUT_EN
            if (state_q != StIdle) cnt_q <= cnt_q + 1'b1;
`endif
            unique case (state_q)
               StIdle: begin
                  if (|pe_req) begin
                     owner_q   <= win_idx;
                     rr_ptr_q  <= next_ptr;
                     pe_gnt    <= win_gnt;
                     mem.req   <= 1'b1;
                     mem.we    <= win_we;
                     mem.addr  <= win_addr;
                     mem.wdata <= win_wdata;
                     state_q   <= StIssue;
`ifdef DMEM_ARB_TIMEOUT_EN
                     cnt_q     <= '0;
`endif
                  end
               end
               StIssue: begin
                  if (mem.ready) begin
                     mem.req <= 1'b0;
                     if (mem.we) begin
                        pe_resp_valid[owner_q] <= 1'b1;
                        state_q                <= StIdle;
                     end else begin
                        state_q <= StWaitRd;
                     end
                  end
               end
               StWaitRd: begin
                  if (mem.rvalid) begin
                     for (int unsigned i = 0; i < NUM_PE; i++) begin
                        if (owner_q == IdxW'(i)) begin
                           pe_rdata[slice_lo(i, DATA_W) +: DATA_W] <= mem.rdata;
                        end
                     end
                     pe_resp_valid[owner_q] <= 1'b1;
                     state_q                <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
